// File: rtl/i2c_transaction_arbiter.sv
// Round-robin arbiter sharing one I2C controller transaction port among NUM_REQUESTERS clients.
// The winner's descriptor is latched and held to completion; read bytes are routed back to it.

module i2c_transaction_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int IDX_W          = $clog2(NUM_REQUESTERS)
) (
    input  logic                          clk,
    input  logic                          async_rst_n,
    input  logic                          clk_en,
    input  logic [NUM_REQUESTERS-1:0]     req_enable,
    input  logic [NUM_REQUESTERS-1:0]     req_valid,
    output logic [NUM_REQUESTERS-1:0]     req_ack,
    output logic [NUM_REQUESTERS-1:0]     req_error,
    input  logic [NUM_REQUESTERS-1:0]     req_ten_bit,
    input  logic [NUM_REQUESTERS-1:0]     req_rw,
    input  logic [8*NUM_REQUESTERS-1:0]   req_length,
    input  logic [10*NUM_REQUESTERS-1:0]  req_periph_addr,
    input  logic [8*NUM_REQUESTERS-1:0]   req_reg_addr,
    input  logic [8*NUM_REQUESTERS-1:0]   req_write_data,
    output logic [NUM_REQUESTERS-1:0]     rd_valid,
    input  logic [NUM_REQUESTERS-1:0]     rd_ready,
    output logic                          rd_last,
    output logic [7:0]                    rd_data,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy,
    output logic                          transaction_req,
    input  logic                          transaction_ack,
    output logic [7:0]                    transaction_length,
    output logic                          transaction_rw,
    output logic [9:0]                    transaction_peripheral_address,
    output logic [7:0]                    transaction_register_address,
    output logic [7:0]                    transaction_write_data,
    output logic                          ten_bit_addressing_enabled,
    input  logic                          read_req,
    output logic                          read_ack,
    input  logic                          read_last,
    input  logic [7:0]                    read_data
);

    localparam int N = NUM_REQUESTERS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [N-1:0]     err_q, err_d;
    logic             treq_q, treq_d;
    logic             busy_q, busy_d;
    logic [7:0]       len_q, len_d;
    logic             rw_q, rw_d;
    logic [9:0]       paddr_q, paddr_d;
    logic [7:0]       raddr_q, raddr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             ten_q, ten_d;

    logic [7:0]       len_arr   [N];
    logic [9:0]       paddr_arr [N];
    logic [7:0]       raddr_arr [N];
    logic [7:0]       wdata_arr [N];
    logic [N-1:0]     cand;
    logic [N-1:0]     win_oh;
    logic [N-1:0]     grant_oh;
    logic [IDX_W-1:0] win;
    logic             found;
    logic             in_read;

    for (genvar g = 0; g < N; g++) begin : g_client
        assign len_arr[g]   = req_length[8*g +: 8];
        assign paddr_arr[g] = req_periph_addr[10*g +: 10];
        assign raddr_arr[g] = req_reg_addr[8*g +: 8];
        assign wdata_arr[g] = req_write_data[8*g +: 8];
        assign win_oh[g]    = (win == IDX_W'(g));
        assign grant_oh[g]  = (grant_q == IDX_W'(g));
    end

    assign cand = req_valid & req_enable;

    // Search upward from the last grant so the previous winner is considered last.
    always_comb begin : arbitrate
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = grant_q;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(grant_q) + k) % N;
            if (!found && cand[IDX_W'(idx)]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    // Read path is a pure mux so bytes pass through with no added latency.
    assign in_read  = (state_q == READ);
    assign rd_valid = (in_read && read_req) ? grant_oh : '0;
    assign read_ack = in_read & rd_ready[grant_q];
    assign rd_data  = in_read ? read_data : 8'd0;
    assign rd_last  = in_read & read_last;

    always_comb begin
        // NOTE: every _d starts as its _q so no branch below can leave one unassigned and infer a latch.
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        err_d   = err_q;
        treq_d  = treq_q;
        busy_d  = busy_q;
        len_d   = len_q;
        rw_d    = rw_q;
        paddr_d = paddr_q;
        raddr_d = raddr_q;
        wdata_d = wdata_q;
        ten_d   = ten_q;

        if (clk_en) begin
            ack_d = '0;
            err_d = '0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_d = win;
                        len_d   = len_arr[win];
                        rw_d    = req_rw[win];
                        paddr_d = paddr_arr[win];
                        raddr_d = raddr_arr[win];
                        wdata_d = wdata_arr[win];
                        ten_d   = req_ten_bit[win];
                        if (len_arr[win] != 8'd0) begin
                            ack_d   = win_oh;
                            treq_d  = 1'b1;
                            busy_d  = 1'b1;
                            state_d = ISSUE;
                        end else begin
                            err_d = win_oh;
                        end
                    end
                end
                ISSUE: begin
                    if (transaction_ack) begin
                        treq_d = 1'b0;
                        if (rw_q) begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
                READ: begin
                    if (read_req && read_ack && read_last) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    treq_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= IDLE;
            grant_q <= IDX_W'(N - 1);
            ack_q   <= '0;
            err_q   <= '0;
            treq_q  <= 1'b0;
            busy_q  <= 1'b0;
            len_q   <= 8'd0;
            rw_q    <= 1'b0;
            paddr_q <= 10'd0;
            raddr_q <= 8'd0;
            wdata_q <= 8'd0;
            ten_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            treq_q  <= treq_d;
            busy_q  <= busy_d;
            len_q   <= len_d;
            rw_q    <= rw_d;
            paddr_q <= paddr_d;
            raddr_q <= raddr_d;
            wdata_q <= wdata_d;
            ten_q   <= ten_d;
        end
    end

    assign req_ack                        = ack_q;
    assign req_error                      = err_q;
    assign grant_idx                      = grant_q;
    assign busy                           = busy_q;
    assign transaction_req                = treq_q;
    assign transaction_length             = len_q;
    assign transaction_rw                 = rw_q;
    assign transaction_peripheral_address = paddr_q;
    assign transaction_register_address   = raddr_q;
    assign transaction_write_data         = wdata_q;
    assign ten_bit_addressing_enabled     = ten_q;

endmodule

// File: doc/i2c_transaction_arbiter.md
# i2c_transaction_arbiter

Shares one `i2c_top_generic` transaction port among `NUM_REQUESTERS` clients with round-robin arbitration. The block latches a winner's transaction descriptor and drives it downstream. It holds the grant until the transaction completes and routes read bytes back to the winning client. It sits between the register/DMA-side requesters and the I2C controller; its downstream ports connect one-to-one to the controller's transaction, read and addressing-mode inputs.

## Interface

Parameters:
- `NUM_REQUESTERS`, default 4: number of clients, 2..8.
- `IDX_W`, default `$clog2(NUM_REQUESTERS)`: grant index width.

Ports:
- `clk`  in  1  system clock
- `async_rst_n`  in  1  asynchronous active-low reset
- `clk_en`  in  1  global advance enable; state and registers hold when low
- `req_enable`  in  N  per-client enable mask; a disabled client never wins
- `req_valid`  in  N  client transaction request, level, held until `req_ack`
- `req_ack`  out  N  one-hot, one qualified cycle: descriptor accepted
- `req_error`  out  N  one-hot, one qualified cycle: descriptor rejected (length 0)
- `req_ten_bit`  in  N  per-client 10-bit addressing select
- `req_rw`  in  N  0: read, 1: write
- `req_length`  in  8N  byte count, client i at [8i+7:8i]
- `req_periph_addr`  in  10N  peripheral address
- `req_reg_addr`  in  8N  register address
- `req_write_data`  in  8N  write byte
- `rd_valid`  out  N  read byte available to the granted client
- `rd_ready`  in  N  client accepts read byte
- `rd_last`  out  1  final byte of the read
- `rd_data`  out  8  read byte, shared bus
- `grant_idx`  out  IDX_W  current or last granted client
- `busy`  out  1  a transaction is latched
- `transaction_req`  out  1  to controller
- `transaction_ack`  in  1  from controller
- `transaction_length`  out  8  latched descriptor field
- `transaction_rw`  out  1  latched descriptor field
- `transaction_peripheral_address`  out  10  latched descriptor field
- `transaction_register_address`  out  8  latched descriptor field
- `transaction_write_data`  out  8  latched descriptor field
- `ten_bit_addressing_enabled`  out  1  latched descriptor field
- `read_req`  in  1  from controller
- `read_ack`  out  1  to controller
- `read_last`  in  1  from controller
- `read_data`  in  8  from controller

## Operation

- **States.** The FSM has three states: IDLE, ISSUE and READ. All transitions require `clk_en`=1.
- **IDLE.**
  - Candidates are `req_valid & req_enable`.
  - The winner is the first candidate found searching upward from `grant_idx+1`, wrapping modulo N.
  - On a win, the block latches all of the winner's descriptor fields and updates `grant_idx`.
  - If the latched length is nonzero, the block pulses `req_ack[winner]` and goes to ISSUE.
  - If the latched length is 0, the block pulses `req_error[winner]`, stays in IDLE and advances `grant_idx`. No downstream activity occurs.
- **ISSUE.**
  - `transaction_req`=1 with stable latched fields.
  - On `transaction_ack`: a write (`rw`=1) goes to IDLE; a read goes to READ.
- **READ.**
  - `rd_valid[grant_idx]`=`read_req`; all other `rd_valid` bits are 0.
  - `rd_data`=`read_data` and `rd_last`=`read_last`.
  - `read_ack`=`rd_ready[grant_idx]`; all other `rd_ready` bits are ignored.
  - On `read_req & read_ack & read_last`, the block goes to IDLE.
- **Outputs outside READ.** `rd_valid`=0, `read_ack`=0, `rd_data`=0, `rd_last`=0.
- **`busy`.** `busy`=1 in ISSUE and READ.
- **Mid-transaction changes.** Deasserting `req_enable` or `req_valid` while granted has no effect on the transaction in flight.
- **Reset.**
  - `async_rst_n` low forces IDLE immediately.
  - `grant_idx` resets to N-1, so client 0 has first priority.
  - All outputs reset to 0, including latched fields and `ten_bit_addressing_enabled`.
  - Reset mid-transaction abandons it; the controller shares the same reset.

## Timing

- **Grant latency.** With `req_valid` sampled high in IDLE at edge T, `req_ack` and `transaction_req` are high after T. `req_ack` lasts one `clk_en`-qualified cycle.
- **Minimum gap.** At least one IDLE cycle separates the completion edge from the next `transaction_req`.
- **Registered outputs.** `transaction_req`, the descriptor fields, `req_ack`, `req_error`, `grant_idx` and `busy` are registered.
- **Combinational outputs.** The read path is combinational mux, zero added latency: `rd_valid`, `rd_data`, `rd_last` and `read_ack`.
- **Client re-request.** A client holding `req_valid` after `req_ack` is a new request. It competes again, after all other candidates in rotation.
- **`clk_en` low.** All registers hold, and pulses stretch until the next qualified cycle. Combinational read forwarding stays active, but completion is only recognized when `clk_en`=1.
- **`transaction_ack` outside ISSUE.** Ignored.

## Test plan

- **Reset and first grant.** Reset, then `req_valid`=4'b1111 with all enabled. Grants follow the order 0,1,2,3,0, and each `req_ack` is a single cycle.
- **Write pass-through.** Client 2 requests a write with length 1, addr 10'h050, reg 8'h1A, data 8'hC3. Downstream fields match the request, `transaction_req` drops the cycle after `transaction_ack`, and the FSM returns to IDLE.
- **Read routing.** Client 1 requests a read with length 3. The controller supplies bytes 8'h11, 8'h22, 8'h33, with last set on the third. Only `rd_valid[1]` toggles. A stall with `rd_ready[1]`=0 holds `read_ack`=0. After the last byte, the FSM returns to IDLE.
- **Zero length and masking.** Client 3 requests with length 0 and gets a `req_error[3]` pulse and no `transaction_req`. With `req_enable[0]`=0 and clients 0 and 1 valid, client 1 wins.
- **`clk_en` gating.** Hold `clk_en` low during ISSUE while `transaction_ack` pulses. No state change occurs; the FSM advances once `clk_en`=1 with ack present.
- **Reset mid-read.** Assert `async_rst_n` low during READ. All outputs are 0 immediately and `grant_idx` is N-1. The next grant goes to the lowest-indexed valid client.
